// File: rtl/riscv_fwd_pkg.sv
// Shared types and helpers for the EX-stage operand forwarding / load-use hazard unit.
package riscv_fwd_pkg;

   localparam int DEF_REG_AW = 5;

   // Encoding follows the input order of the EX-stage operand muxes.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10,
      FWD_RET = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic                  valid;
      logic [DEF_REG_AW-1:0] rd;
      logic                  we;
      logic                  is_load;
   } fwd_tag_t;

   // A source hits a stage when that stage will write the register being read; x0 never hits.
   function automatic logic tag_hit(input fwd_tag_t tag, input logic [DEF_REG_AW-1:0] rs,
                                    input logic rs_used);
      return tag.valid & tag.we & (tag.rd == rs) & (rs != '0) & rs_used;
   endfunction

   function automatic fwd_sel_e pick_sel(input logic hit_ex, input logic hit_mem,
                                         input logic hit_wb);
      fwd_sel_e sel;
      if (hit_ex)       sel = FWD_MEM;
      else if (hit_mem) sel = FWD_WB;
      else if (hit_wb)  sel = FWD_RET;
      else              sel = FWD_RF;
      return sel;
   endfunction

endpackage

// File: rtl/fwd_tag_reg.sv
// One destination-tag pipeline stage: holds on i_hold, loads an empty tag on i_clear.
module fwd_tag_reg
   import riscv_fwd_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_hold,
   input  logic     i_clear,
   input  fwd_tag_t i_d,
   output fwd_tag_t o_q
);

   fwd_tag_t r_tag;

   // NOTE: sequential state is always written with <= so every stage samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
      end else if (!i_hold) begin
         r_tag <= i_clear ? '0 : i_d;
      end
   end

   assign o_q = r_tag;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select generator and load-use stall detector for a 5-stage RISC-V pipeline.
// Optional statistics counters are enabled with `define FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
   import riscv_fwd_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_hold,
   input  logic              flush_ex,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall_id,
   output logic              bubble_ex
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  fwd_cnt
`endif
);

   fwd_tag_t w_id_tag;
   fwd_tag_t w_ex_tag;
   fwd_tag_t w_mem_tag;
   fwd_tag_t w_wb_tag;
   fwd_tag_t w_ret_tag;

   logic     w_a_ex, w_a_mem, w_a_wb;
   logic     w_b_ex, w_b_mem, w_b_wb;
   logic     w_load_use;
   logic     w_ex_load_en;
   fwd_sel_e w_next_a, w_next_b;
   fwd_sel_e r_fwd_a_sel, r_fwd_b_sel;

   assign w_id_tag = '{valid: id_valid, rd: id_rd, we: id_rd_we, is_load: id_is_load};

   // Hits are taken against the stages the ID instruction will forward from once it is in EX.
   assign w_a_ex  = id_valid & tag_hit(w_ex_tag,  id_rs1, id_rs1_used);
   assign w_a_mem = id_valid & tag_hit(w_mem_tag, id_rs1, id_rs1_used);
   assign w_a_wb  = id_valid & tag_hit(w_wb_tag,  id_rs1, id_rs1_used);
   assign w_b_ex  = id_valid & tag_hit(w_ex_tag,  id_rs2, id_rs2_used);
   assign w_b_mem = id_valid & tag_hit(w_mem_tag, id_rs2, id_rs2_used);
   assign w_b_wb  = id_valid & tag_hit(w_wb_tag,  id_rs2, id_rs2_used);

   // A flushed or frozen ID instruction cannot stall; the flush also wins over the load-use.
   assign w_load_use   = (w_a_ex | w_b_ex) & w_ex_tag.is_load & ~flush_ex & ~pipe_hold;
   assign w_ex_load_en = id_valid & ~flush_ex & ~w_load_use;

   assign w_next_a = w_ex_load_en ? pick_sel(w_a_ex, w_a_mem, w_a_wb) : FWD_RF;
   assign w_next_b = w_ex_load_en ? pick_sel(w_b_ex, w_b_mem, w_b_wb) : FWD_RF;

   fwd_tag_reg u_tag_ex (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (pipe_hold),
      .i_clear (~w_ex_load_en),
      .i_d     (w_id_tag),
      .o_q     (w_ex_tag)
   );

   fwd_tag_reg u_tag_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (pipe_hold),
      .i_clear (1'b0),
      .i_d     (w_ex_tag),
      .o_q     (w_mem_tag)
   );

   fwd_tag_reg u_tag_wb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (pipe_hold),
      .i_clear (1'b0),
      .i_d     (w_mem_tag),
      .o_q     (w_wb_tag)
   );

   fwd_tag_reg u_tag_ret (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (pipe_hold),
      .i_clear (1'b0),
      .i_d     (w_wb_tag),
      .o_q     (w_ret_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_a_sel <= FWD_RF;
         r_fwd_b_sel <= FWD_RF;
      end else if (!pipe_hold) begin
         r_fwd_a_sel <= w_next_a;
         r_fwd_b_sel <= w_next_b;
      end
   end

   assign fwd_a_sel = r_fwd_a_sel;
   assign fwd_b_sel = r_fwd_b_sel;
   assign stall_id  = w_load_use;
   assign bubble_ex = w_load_use;

   // The retired stage only exists so a WB hit has a register to forward from.
   logic w_unused;
   assign w_unused = ^{w_mem_tag.is_load, w_wb_tag.is_load, w_ret_tag};

`ifdef FWD_HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_fwd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (stall_id && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (!pipe_hold && ((w_next_a != FWD_RF) || (w_next_b != FWD_RF)) && (r_fwd_cnt != '1)) begin
            r_fwd_cnt <= r_fwd_cnt + 1'b1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign fwd_cnt   = r_fwd_cnt;
`else
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, reset sequence, random vs. history model.
module tb_fwd_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic       pipe_hold, flush_ex, id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall_id, bubble_ex;

   int n_checks = 0;
   int n_errors = 0;

   fwd_hazard_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_hold   (pipe_hold),
      .flush_ex    (flush_ex),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_rd_we    (id_rd_we),
      .id_is_load  (id_is_load),
      .fwd_a_sel   (fwd_a_sel),
      .fwd_b_sel   (fwd_b_sel),
      .stall_id    (stall_id),
      .bubble_ex   (bubble_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         hold, flush, valid;
      logic [4:0] rs1;
      bit         u1;
      logic [4:0] rs2;
      bit         u2;
      logic [4:0] rd;
      bit         we, ld;
      logic [1:0] ea, eb;
      bit         es;
   } vec_t;

   // Reference model: list of instructions that entered EX, newest first (bubbles included).
   typedef struct {
      bit         v;
      logic [4:0] rd;
      bit         we;
      bit         ld;
   } ins_t;

   ins_t       hist[$];
   logic [1:0] m_a, m_b;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit h, input bit f, input bit v, input int rs1, input bit u1,
                               input int rs2, input bit u2, input int rd, input bit we, input bit ld,
                               input int ea, input int eb, input bit es);
      vec_t r;
      r.hold = h;  r.flush = f;  r.valid = v;
      r.rs1 = 5'(rs1);  r.u1 = u1;  r.rs2 = 5'(rs2);  r.u2 = u2;
      r.rd = 5'(rd);  r.we = we;  r.ld = ld;
      r.ea = 2'(ea);  r.eb = 2'(eb);  r.es = es;
      return r;
   endfunction

   function automatic vec_t nop(input int ea, input int eb);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0);
   endfunction

   // Select = how many instructions ago the youngest writer of rs entered EX (1..3), else 0.
   function automatic logic [1:0] dist_sel(input logic [4:0] rs, input logic used);
      if (!id_valid || !used || rs == 5'd0) return 2'd0;
      for (int d = 0; d < 3 && d < hist.size(); d++) begin
         if (hist[d].v && hist[d].we && hist[d].rd == rs) return 2'(d + 1);
      end
      return 2'd0;
   endfunction

   function automatic bit model_load_use();
      if (pipe_hold || flush_ex || hist.size() == 0 || !hist[0].ld) return 1'b0;
      return (dist_sel(id_rs1, id_rs1_used) == 2'd1) || (dist_sel(id_rs2, id_rs2_used) == 2'd1);
   endfunction

   task automatic model_reset();
      hist.delete();
      m_a = 2'd0;
      m_b = 2'd0;
   endtask

   task automatic model_edge();
      bit   enters;
      ins_t ins;
      if (pipe_hold) return;
      enters = id_valid && !flush_ex && !model_load_use();
      ins.v  = enters;
      ins.rd = id_rd;
      ins.we = id_rd_we;
      ins.ld = id_is_load;
      m_a = enters ? dist_sel(id_rs1, id_rs1_used) : 2'd0;
      m_b = enters ? dist_sel(id_rs2, id_rs2_used) : 2'd0;
      hist.push_front(ins);
      if (hist.size() > 4) void'(hist.pop_back());
   endtask

   task automatic apply(input vec_t v);
      pipe_hold   = v.hold;
      flush_ex    = v.flush;
      id_valid    = v.valid;
      id_rs1      = v.rs1;
      id_rs1_used = v.u1;
      id_rs2      = v.rs2;
      id_rs2_used = v.u2;
      id_rd       = v.rd;
      id_rd_we    = v.we;
      id_is_load  = v.ld;
   endtask

   // Drive one ID cycle, compare outputs mid-cycle, then advance the model on the edge.
   task automatic run_vec(input vec_t v, input bit use_model, input string tag);
      logic [1:0] ea, eb;
      logic       es;
      apply(v);
      @(negedge clk);
      if (use_model) begin
         ea = m_a;  eb = m_b;  es = model_load_use();
      end else begin
         ea = v.ea;  eb = v.eb;  es = v.es;
      end
      check({tag, " fwd_a_sel"}, fwd_a_sel, ea);
      check({tag, " fwd_b_sel"}, fwd_b_sel, eb);
      check({tag, " stall_id"}, {1'b0, stall_id}, {1'b0, es});
      check({tag, " bubble_ex"}, {1'b0, bubble_ex}, {1'b0, es});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      // Directed table: each entry is one ID cycle; expectations are outputs seen during that cycle.
      tbl.push_back(mk(0,0,1, 1,1, 2,1,  5,1,0, 0,0,0));  // ADD x5
      tbl.push_back(mk(0,0,1, 5,1, 7,1,  6,1,0, 0,0,0));  // SUB x6,x5,x7
      tbl.push_back(nop(1,0));                            // SUB in EX: A from EX/MEM
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  5,1,0, 0,0,0));  // producer x5
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 10,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 1,1, 5,1, 11,1,0, 0,0,0));  // consumer at distance 2
      tbl.push_back(nop(0,2));
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  5,1,0, 0,0,0));  // producer x5
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 12,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 13,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 0,0, 5,1, 20,1,0, 0,0,0));  // consumer at distance 3
      tbl.push_back(nop(0,3));
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  5,1,0, 0,0,0));  // producer x5
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 12,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 13,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 1,1, 2,1, 14,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 0,0, 5,1, 20,1,0, 0,0,0));  // consumer at distance 4
      tbl.push_back(nop(0,0));
      tbl.push_back(mk(0,0,1, 2,1, 0,0,  9,1,1, 0,0,0));  // LW x9
      tbl.push_back(mk(0,0,1, 9,1, 9,1, 15,1,0, 0,0,1));  // ADD x15,x9,x9 stalls
      tbl.push_back(mk(0,0,1, 9,1, 9,1, 15,1,0, 0,0,0));  // re-presented after stall
      tbl.push_back(nop(2,2));
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  3,1,0, 0,0,0));  // x3 at distance 2
      tbl.push_back(mk(0,0,1, 1,1, 2,1,  3,1,0, 0,0,0));  // x3 at distance 1
      tbl.push_back(mk(0,0,1, 3,1, 3,1, 16,1,0, 0,0,0));
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  0,1,1, 1,1,0));  // LW x0
      tbl.push_back(mk(0,0,1, 0,1, 0,1, 17,1,0, 0,0,0));  // reads x0: no stall
      tbl.push_back(nop(0,0));
      tbl.push_back(mk(0,0,1, 0,0, 0,0,  7,1,0, 0,0,0));  // producer x7
      tbl.push_back(mk(0,0,1, 7,1, 2,1, 16,1,0, 0,0,0));
      tbl.push_back(mk(1,0,1, 7,1, 7,1, 18,1,0, 1,0,0));  // hold x3
      tbl.push_back(mk(1,0,1, 7,1, 7,1, 18,1,0, 1,0,0));
      tbl.push_back(mk(1,0,1, 7,1, 7,1, 18,1,0, 1,0,0));
      tbl.push_back(mk(0,0,1, 7,1, 7,1, 18,1,0, 1,0,0));
      tbl.push_back(nop(2,2));
      tbl.push_back(mk(0,0,1, 2,1, 0,0,  9,1,1, 0,0,0));  // LW x9
      tbl.push_back(mk(0,1,1, 9,1, 9,1, 15,1,0, 0,0,0));  // flush beats load-use
      tbl.push_back(nop(0,0));
      tbl.push_back(mk(0,0,1, 2,1, 0,0,  9,1,1, 0,0,0));  // LW x9
      tbl.push_back(mk(1,0,1, 9,1, 9,1, 15,1,0, 0,0,0));  // hold masks stall
      tbl.push_back(mk(0,0,1, 9,1, 9,1, 15,1,0, 0,0,1));
      tbl.push_back(mk(0,0,1, 9,1, 9,1, 15,1,0, 0,0,0));
      tbl.push_back(nop(2,2));

      rst_n = 1'b0;
      apply(nop(0,0));
      model_reset();
      #12;
      check("reset fwd_a_sel", fwd_a_sel, 2'd0);
      check("reset fwd_b_sel", fwd_b_sel, 2'd0);
      check("reset stall_id", {1'b0, stall_id}, 2'd0);
      check("reset bubble_ex", {1'b0, bubble_ex}, 2'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a forward plus a pending load-use.
      run_vec(mk(0,0,1, 0,0, 0,0, 5,1,0, 0,0,0), 1'b0, "rst_seq0");
      run_vec(mk(0,0,1, 5,1, 0,0, 9,1,1, 0,0,0), 1'b0, "rst_seq1");
      apply(mk(0,0,1, 9,1, 9,1, 15,1,0, 0,0,0));
      @(negedge clk);
      check("pre-reset fwd_a_sel", fwd_a_sel, 2'd1);
      check("pre-reset stall_id", {1'b0, stall_id}, 2'd1);
      rst_n = 1'b0;
      #1;
      check("async reset fwd_a_sel", fwd_a_sel, 2'd0);
      check("async reset fwd_b_sel", fwd_b_sel, 2'd0);
      check("async reset stall_id", {1'b0, stall_id}, 2'd0);
      check("async reset bubble_ex", {1'b0, bubble_ex}, 2'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      run_vec(mk(0,0,1, 9,1, 5,1, 15,1,0, 0,0,0), 1'b0, "post-reset consumer");
      run_vec(nop(0,0), 1'b0, "post-reset ex");

      // Randomized traffic on a small register set so hazards are frequent.
      for (int i = 0; i < 3000; i++) begin
         rv.hold  = ($urandom_range(0, 9) == 0);
         rv.flush = ($urandom_range(0, 9) == 0);
         rv.valid = ($urandom_range(0, 7) != 0);
         rv.rs1   = 5'($urandom_range(0, 3));
         rv.u1    = ($urandom_range(0, 3) != 0);
         rv.rs2   = 5'($urandom_range(0, 3));
         rv.u2    = ($urandom_range(0, 3) != 0);
         rv.rd    = 5'($urandom_range(0, 3));
         rv.we    = ($urandom_range(0, 4) != 0);
         rv.ld    = ($urandom_range(0, 2) == 0);
         rv.ea    = 2'd0;
         rv.eb    = 2'd0;
         rv.es    = 1'b0;
         run_vec(rv, 1'b1, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Drives the 2-bit select inputs of the EX-stage operand 4:1 muxes (ALU operand A and B) in the 5-stage RISC-V pipeline.
- Tracks destination-register tags of in-flight instructions through its own EX/MEM/WB/RET tag pipeline.
- Generates forwarding selects one cycle ahead (registered), and detects load-use hazards, asserting the stall/bubble controls.

Parameters:
REG_AW, 5, register-index width (32 architectural registers)
CNT_W, 32, width of the statistics counters (used only with the optional feature)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pipe_hold  in  1  global pipeline freeze (memory wait); all state holds
flush_ex  in  1  instruction leaving ID is killed (branch redirect); enters EX as a bubble
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source 1 index
id_rs2  in  REG_AW  ID source 2 index
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination index
id_rd_we  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
fwd_a_sel  out  2  select for the operand-A mux of the instruction now in EX
fwd_b_sel  out  2  select for the operand-B mux of the instruction now in EX
stall_id  out  1  hold PC and IF/ID this cycle
bubble_ex  out  1  insert a NOP into ID/EX at next edge

Behaviour:
- Select encoding (matches mux input order): 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result, 11 = RET (retired-writeback hold register).
- Tag stages EX, MEM, WB, RET each hold {valid, rd, we, is_load}. Each non-held edge shifts EX->MEM->WB->RET, and ID->EX.
- Reset (async, rst_n low): all tag valids 0; fwd_a_sel = fwd_b_sel = 00; stall_id = 0; bubble_ex = 0.
- Hazard match on stage S for source rs: S.valid & S.we & (S.rd == rs) & (rs != 0) & rs_used & id_valid.
- Load-use (combinational): a match of either source against the EX stage with EX.is_load -> stall_id = 1 and bubble_ex = 1 in the same cycle.
  - Qualified: forced 0 when flush_ex or pipe_hold.
- Next-select computation at the ID edge, against the stages the instruction will see when it is in EX:
  - current EX tag -> 01
  - else current MEM -> 10
  - else current WB -> 11
  - else 00
  - Youngest wins.
- Selects are registered and valid during the instruction's EX cycle. Latency from ID inputs to select: 1 clock.
- Bubble, flush_ex, or !id_valid: the EX tag valid is cleared and the registered selects load 00.
- Stall cycle: ID->EX loads a bubble (valid 0, selects 00). EX, MEM and WB shift normally, so the load advances and the following cycle forwards from MEM/WB (10).
- pipe_hold = 1: every register holds, including the selects. stall_id and bubble_ex are 0. Holding across multiple cycles must not corrupt forwarding.
- flush_ex together with a load-use condition: flush wins, no stall.
- x0: never forwarded, never causes a stall.
- Reset asserted mid-operation: the next cycle after release behaves as an empty pipeline.

Optional Feature:
FWD_HAZARD_STATS_EN
- Defined: adds output ports stall_cnt, fwd_cnt (CNT_W each), both reset to 0.
  - stall_cnt increments on each cycle with stall_id = 1.
  - fwd_cnt increments on each non-held edge where a loaded select is nonzero (A or B, counted once per instruction).
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_fwd_pkg:
  - enum fwd_sel_e {FWD_RF, FWD_MEM, FWD_WB, FWD_RET} (2-bit)
  - struct fwd_tag_t {valid, rd, we, is_load}
  - REG_AW default constant
- One sub-module fwd_tag_reg: a single tag stage register with hold and clear inputs, instantiated four times.

Test Plan:
- Back-to-back dependency: ADD x5 then SUB x6,x5,x7 -> SUB in EX with fwd_a_sel = 01, fwd_b_sel = 00.
- Distance 2 and 3: producer x5, one and two unrelated instructions, then consumer rs2 = x5 -> fwd_b_sel = 10, then 11. At distance 4 -> 00.
- Load-use: LW x9 then ADD x1,x9,x9 -> stall_id = bubble_ex = 1 for exactly 1 cycle; ADD then enters EX with fwd_a_sel = fwd_b_sel = 10.
- Priority and x0:
  - x3 written at distances 1 and 2 -> select 01 (youngest).
  - Producer rd = x0 followed by a consumer of x0 -> 00, no stall.
- Hold and flush:
  - pipe_hold asserted 3 cycles during a pending forward -> selects unchanged, valid after release.
  - flush_ex coinciding with a load-use -> no stall, next EX selects 00.
- Reset: rst_n pulsed low mid-stream -> outputs 0 immediately (async); the first consumer after reset sees 00.
